ahb_bram_ctrl: RTL and testbench

AHB-Lite slave front end that feeds the team's dual-address block RAM, which has byte-lane write enables and a 1-cycle synchronous read.
- Write path: converts AHB address/data phases into the RAM's write address, 4-bit byte-lane mask and lane-aligned write data.
- Read path: issues the read address in the AHB address phase, so reads complete with zero wait states.
- Hazards: resolves read-after-write collisions on the same word.
- Errors: flags illegal transfers with the two-cycle AHB ERROR response.

---
 rtl/ahb_bram_ctrl_pkg.sv | 33 +++
 rtl/ahb_lane_decode.sv | 29 ++
 rtl/ahb_bram_ctrl.sv | 149 ++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared encodings for the AHB block-RAM front end: HTRANS/HSIZE codes, FSM states
// and the lane-merge helper used when BRAM_CTRL_FWD_EN forwarding is built in.
package ahb_bram_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ERR1    = 2'd1,
    ST_ERR2    = 2'd2,
    ST_RDSTALL = 2'd3
  } state_e;

  // Byte lane n takes fresh[n] where mask[n] is set, otherwise old[n].
  function automatic logic [31:0] lane_merge(input logic [3:0]  mask,
                                             input logic [31:0] fresh,
                                             input logic [31:0] old);
    logic [31:0] r;
    for (int n = 0; n < 4; n++)
      r[8*n +: 8] = mask[n] ? fresh[8*n +: 8] : old[8*n +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ahb_lane_decode.sv
// AHB size/alignment decode: byte-lane mask for a 32-bit bus plus an illegal flag
// for unsupported sizes and misaligned half/word transfers.
module ahb_lane_decode
  import ahb_bram_ctrl_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);

  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask    = 4'b1111;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a byte-enabled, 1-cycle-read block RAM.
// Define BRAM_CTRL_FWD_EN to forward colliding write data instead of stalling the read.
module ahb_bram_ctrl
  import ahb_bram_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic                      HREADY,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [MEM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [3:0]                ram_wr_be,
  output logic [31:0]               ram_wr_data,
  output logic [MEM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [31:0]               ram_rd_data
);

  localparam int AW = MEM_ADDR_WIDTH;

  state_e          state, state_nxt;
  logic [3:0]      mask;
  logic            illegal;
  logic            is_xfer, accept, acc_ok, collide;
  logic [AW-1:0]   word;
  logic            wr_pend, rd_pend;
  logic [AW-1:0]   wr_addr_q;
  logic [3:0]      wr_mask_q;
  logic [31:0]     rd_word;
  logic            unused_haddr;

  ahb_lane_decode u_dec (
    .size    (HSIZE),
    .addr_lo (HADDR[1:0]),
    .mask    (mask),
    .illegal (illegal)
  );

  // Upper address bits alias onto the RAM.
  assign unused_haddr = ^HADDR[31:AW+2];
  assign word         = HADDR[AW+1:2];
  assign is_xfer      = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign accept       = HSEL & HREADY & is_xfer;
  assign acc_ok       = accept & ~illegal;
  // The RAM hands back pre-write data when a read targets the word being written now.
  assign collide      = acc_ok & ~HWRITE & wr_pend & (word == wr_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= 4'b0000;
    end else if (HREADY) begin
      wr_pend <= acc_ok & HWRITE;
      rd_pend <= acc_ok & ~HWRITE;
      if (acc_ok & HWRITE) begin
        wr_addr_q <= word;
        wr_mask_q <= mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ERR1:    state_nxt = ST_ERR2;
      ST_RDSTALL: state_nxt = ST_IDLE;
      default: begin
        if (accept & illegal)
          state_nxt = ST_ERR1;
`ifndef BRAM_CTRL_FWD_EN
        else if (collide)
          state_nxt = ST_RDSTALL;
`endif
        else
          state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2:    HRESP     = 1'b1;
      ST_RDSTALL: HREADYOUT = 1'b0;
      default: ;
    endcase
  end

  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_be   = wr_pend ? wr_mask_q : 4'b0000;
  assign ram_wr_data = HWDATA;

`ifdef BRAM_CTRL_FWD_EN
  logic        fwd_vld;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld  <= 1'b0;
      fwd_mask <= 4'b0000;
      fwd_data <= '0;
    end else if (HREADY) begin
      fwd_vld <= collide;
      if (collide) begin
        fwd_mask <= wr_mask_q;
        fwd_data <= HWDATA;
      end
    end
  end

  assign ram_rd_addr = word;
  assign rd_word     = fwd_vld ? lane_merge(fwd_mask, fwd_data, ram_rd_data) : ram_rd_data;
`else
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rd_addr_q <= '0;
    else if (HREADY & acc_ok & ~HWRITE) rd_addr_q <= word;
  end

  // The stall cycle re-reads the word after the write has landed.
  assign ram_rd_addr = (state == ST_RDSTALL) ? rd_addr_q : word;
  assign rd_word     = ram_rd_data;
`endif

  assign HRDATA = rd_pend ? rd_word : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl: transaction-level memory model plus
// per-cycle response expectations, directed cases and randomized traffic.
module tb_ahb_bram_ctrl;

  localparam int AW = 12;
  localparam int NW = 1 << AW;
`ifdef BRAM_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel, hwrite, hready;
  logic [31:0]   haddr, hwdata, hrdata;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hreadyout, hresp;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [3:0]    ram_wr_be;
  logic [31:0]   ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_bram_ctrl #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .ram_wr_addr(ram_wr_addr), .ram_wr_be(ram_wr_be), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // Block RAM stand-in: byte-lane writes, registered read-before-write.
  bit [31:0] ram [NW];
  bit [31:0] rd_q;
  assign ram_rd_data = rd_q;
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (ram_wr_be[n]) ram[ram_wr_addr][8*n +: 8] <= ram_wr_data[8*n +: 8];
    rd_q <= ram[ram_rd_addr];
  end

  typedef struct {
    logic sel; logic [1:0] trans; logic wr;
    logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
  } ap_t;
  typedef struct {
    logic vld; logic wr; logic err; logic stall;
    logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
  } dp_t;

  bit [31:0]   ref_mem [NW];
  ap_t         ap;
  dp_t         dp;
  int          dp_cyc;
  bit          ap_done;
  int          n_cmp, n_bad;
  int          n_wait, n_err_c, n_wr_c;
  logic [31:0] last_rdata;
  logic [3:0]  last_be;

  function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
    if (sz == 3'd0) return 4'b0001 << a;
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit bad(input logic [2:0] sz, input logic [1:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a != 2'd0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic ap_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    ap_t r;
    r.sel = sel; r.trans = tr; r.wr = wr; r.addr = a; r.size = sz; r.wdata = wd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, predict, sample at negedge, advance the model.
  task automatic cycle();
    logic        er, erp, chk;
    logic [3:0]  eb, m;
    logic [31:0] erd;
    dp_t         nd;
    int          wi;
    hsel = ap.sel; htrans = ap.trans; hwrite = ap.wr; haddr = ap.addr; hsize = ap.size;
    hwdata = (dp.vld && dp.wr) ? dp.wdata : $urandom();
    er = 1'b1; erp = 1'b0; eb = 4'b0; chk = 1'b0; erd = 32'h0;
    if (dp.vld) begin
      if (dp.err) begin
        erp = 1'b1;
        er  = (dp_cyc >= 1);
      end else if (dp.wr) eb = lanes(dp.size, dp.addr[1:0]);
      else if (dp.stall && dp_cyc == 0) er = 1'b0;
      else begin
        chk = 1'b1;
        erd = ref_mem[widx(dp.addr)];
      end
    end
    @(negedge clk);
    check("hreadyout", 32'(hreadyout), 32'(er));
    check("hresp", 32'(hresp), 32'(erp));
    check("ram_wr_be", 32'(ram_wr_be), 32'(eb));
    if (eb != 4'b0) begin
      check("ram_wr_addr", 32'(ram_wr_addr), 32'(widx(dp.addr)));
      check("ram_wr_data", ram_wr_data, dp.wdata);
      last_be = ram_wr_be;
    end
    if (ram_wr_be != 4'b0) n_wr_c++;
    if (!hreadyout) n_wait++;
    if (hresp) n_err_c++;
    if (chk) begin
      check("hrdata", hrdata, erd);
      last_rdata = hrdata;
    end
    if (er) begin
      if (dp.vld && dp.wr && !dp.err) begin
        m  = lanes(dp.size, dp.addr[1:0]);
        wi = widx(dp.addr);
        for (int n = 0; n < 4; n++)
          if (m[n]) ref_mem[wi][8*n +: 8] = dp.wdata[8*n +: 8];
      end
      nd.vld   = ap.sel && ap.trans[1];
      nd.wr    = ap.wr;
      nd.err   = nd.vld && bad(ap.size, ap.addr[1:0]);
      nd.addr  = ap.addr;
      nd.size  = ap.size;
      nd.wdata = ap.wdata;
      nd.stall = !FWD && nd.vld && !nd.wr && !nd.err && dp.vld && dp.wr && !dp.err
                 && widx(dp.addr) == widx(nd.addr);
      dp      = nd;
      dp_cyc  = 0;
      ap_done = 1'b1;
    end else begin
      dp_cyc++;
      ap_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ap_t a);
    int g;
    g  = 0;
    ap = a;
    do begin
      cycle();
      g++;
    end while (!ap_done && g < 6);
    if (!ap_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: address phase 0x%08h not accepted in %0d cycles", a.addr, g);
    end
  endtask

  ap_t idle;
  int  wt0, e0, w0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_wait = 0; n_err_c = 0; n_wr_c = 0;
    last_rdata = 32'h0; last_be = 4'h0;
    idle = mk(1'b0, 2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    ap = idle; dp = '{default: '0}; dp_cyc = 0;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_ram_wr_be", 32'(ram_wr_be), 32'd0);
    check("rst_hrdata_known", 32'($isunknown(hrdata)), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word write then non-adjacent read
    wt0 = n_wait;
    issue(mk(1, 2'd2, 1, 32'h10, 3'd2, 32'hDEADBEEF));
    issue(idle);
    check("lit_word_be", 32'(last_be), 32'hF);
    issue(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
    issue(idle);
    check("lit_word_rd", last_rdata, 32'hDEADBEEF);
    check("lit_word_waits", 32'(n_wait - wt0), 32'd0);

    // Byte write into an existing word
    issue(mk(1, 2'd2, 1, 32'h10, 3'd2, 32'h11223344));
    issue(idle);
    issue(mk(1, 2'd2, 1, 32'h13, 3'd0, 32'h5A000000));
    issue(idle);
    check("lit_byte_be", 32'(last_be), 32'h8);
    issue(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
    issue(idle);
    check("lit_byte_rd", last_rdata, 32'h5A223344);

    // Half write immediately followed by a read of the same word
    wt0 = n_wait;
    issue(mk(1, 2'd2, 1, 32'h22, 3'd1, 32'hABCD0000));
    issue(mk(1, 2'd2, 0, 32'h20, 3'd2, 32'h0));
    issue(idle);
    check("lit_coll_rd", last_rdata, 32'hABCD0000);
    check("lit_coll_waits", 32'(n_wait - wt0), FWD ? 32'd0 : 32'd1);

    // Misaligned word write -> two-cycle ERROR, no RAM write
    wt0 = n_wait; e0 = n_err_c; w0 = n_wr_c;
    issue(mk(1, 2'd2, 1, 32'h06, 3'd2, 32'hFFFFFFFF));
    issue(idle);
    check("lit_err_resp_cycles", 32'(n_err_c - e0), 32'd2);
    check("lit_err_wait_cycles", 32'(n_wait - wt0), 32'd1);
    check("lit_err_no_write", 32'(n_wr_c - w0), 32'd0);
    issue(mk(1, 2'd2, 0, 32'h04, 3'd2, 32'h0));
    issue(idle);
    check("lit_err_rd", last_rdata, 32'h0);

    // BUSY / deselected cycles interleaved with reads
    wt0 = n_wait; e0 = n_err_c; w0 = n_wr_c;
    for (int i = 0; i < 6; i++) begin
      issue(mk(1, 2'd2, 0, 32'h10 + 32'(4 * (i % 3)), 3'd2, 32'h0));
      issue(mk(1, 2'd1, 1, 32'h40, 3'd2, 32'hFFFFFFFF));
      issue(mk(0, 2'd2, 1, 32'h44, 3'd2, 32'hFFFFFFFF));
    end
    issue(idle);
    check("lit_busy_no_write", 32'(n_wr_c - w0), 32'd0);
    check("lit_busy_no_wait", 32'(n_wait - wt0), 32'd0);
    check("lit_busy_no_err", 32'(n_err_c - e0), 32'd0);

    // High address bits alias onto the same word
    issue(mk(1, 2'd2, 1, 32'hABC00040, 3'd2, 32'h00000077));
    issue(idle);
    issue(mk(1, 2'd3, 0, 32'h00000040, 3'd2, 32'h0));
    issue(idle);
    check("lit_alias_rd", last_rdata, 32'h00000077);

    // Reset during a write data phase drops the write
    issue(mk(1, 2'd2, 1, 32'h30, 3'd2, 32'hCAFEF00D));
    issue(idle);
    issue(mk(1, 2'd2, 1, 32'h30, 3'd2, 32'h12345678));
    hsel = 1'b0; htrans = 2'd0; hwdata = dp.wdata;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_be", 32'(ram_wr_be), 32'd0);
    check("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_mid_hresp", 32'(hresp), 32'd0);
    #2 rst = 1'b0;
    dp = '{default: '0}; dp_cyc = 0; ap = idle;
    @(posedge clk);
    #1;
    issue(mk(1, 2'd2, 0, 32'h30, 3'd2, 32'h0));
    issue(idle);
    check("lit_rst_keep", last_rdata, 32'hCAFEF00D);

    // Randomized traffic over a few words to provoke collisions
    for (int i = 0; i < 800; i++) begin
      ap_t     a;
      int      w;
      logic [1:0] lo;
      a.sel   = ($urandom_range(0, 99) < 92);
      a.trans = ($urandom_range(0, 9) < 7) ? {1'b1, 1'($urandom_range(0, 1))}
                                           : {1'b0, 1'($urandom_range(0, 1))};
      a.wr    = 1'($urandom_range(0, 1));
      a.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      w       = $urandom_range(0, 7);
      lo      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (a.size == 3'd1) lo[0] = 1'b0;
        if (a.size == 3'd2) lo = 2'd0;
      end
      a.addr          = $urandom();
      a.addr[AW+1:2]  = AW'(w);
      a.addr[1:0]     = lo;
      a.wdata         = $urandom();
      issue(a);
    end
    issue(idle);
    issue(idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
